// File: rtl/keypad_check_core.sv
// Keypad lock control/compare core: key-strobe demux, code comparator
// and BCD attempt counter.
module keypad_check_core #(
  parameter int WIDTH   = 32,
  parameter int CNT_MAX = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             key_valid,
  output logic [1:0]       mode_out,
  input  logic [WIDTH-1:0] ui_code,
  input  logic [WIDTH-1:0] sp_code,
  output logic             code_eq,
  input  logic             attempt_inc,
  output logic [3:0]       attempt_count,
  output logic             attempt_wrap
);

  localparam logic [3:0] CNT_LAST = 4'(CNT_MAX);

  logic [3:0] attempt_count_d;
  logic [3:0] attempt_count_q;
  logic       at_last;

  always_comb begin
    mode_out    = 2'b00;
    mode_out[0] = key_valid & ~sel;
    mode_out[1] = key_valid & sel;
  end

  // Raw bitwise compare; illegal BCD nibbles are not filtered.
  assign code_eq = (ui_code == sp_code);

  assign at_last = (attempt_count_q >= CNT_LAST);

  always_comb begin
    attempt_count_d = attempt_count_q;
    if (attempt_inc) begin
      attempt_count_d = at_last ? 4'd0 : attempt_count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempt_count_q <= 4'd0;
    end else begin
      attempt_count_q <= attempt_count_d;
    end
  end

  assign attempt_count = attempt_count_q;
  assign attempt_wrap  = attempt_inc & (attempt_count_q == CNT_LAST);

endmodule

// File: tb/tb_keypad_check_core.sv
// Directed bench for keypad_check_core: demux, comparator and
// attempt counter including async reset behaviour.
module tb_keypad_check_core;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        key_valid;
  logic [1:0]  mode_out;
  logic [31:0] ui_code;
  logic [31:0] sp_code;
  logic        code_eq;
  logic        attempt_inc;
  logic [3:0]  attempt_count;
  logic        attempt_wrap;

  int checks;
  int errors;

  keypad_check_core dut (
    .clk           (clk),
    .rst           (rst),
    .sel           (sel),
    .key_valid     (key_valid),
    .mode_out      (mode_out),
    .ui_code       (ui_code),
    .sp_code       (sp_code),
    .code_eq       (code_eq),
    .attempt_inc   (attempt_inc),
    .attempt_count (attempt_count),
    .attempt_wrap  (attempt_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_dly();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    attempt_inc = 1'b1;
    edge_dly();
    attempt_inc = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  logic [3:0] exp_seq [10];

  initial begin
    checks = 0;
    errors = 0;
    exp_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    rst = 1'b1;
    sel = 1'b0;
    key_valid = 1'b0;
    ui_code = 32'h0;
    sp_code = 32'h0;
    attempt_inc = 1'b1;

    // 1. reset holds count despite attempt_inc
    repeat (3) edge_dly();
    chk("rst_count", 32'(attempt_count), 32'd0);
    chk("rst_wrap", 32'(attempt_wrap), 32'd0);
    chk("rst_eq_zero", 32'(code_eq), 32'd1);
    rst = 1'b0;
    edge_dly();
    attempt_inc = 1'b0;
    chk("rel_count", 32'(attempt_count), 32'd1);

    // 2. demux
    sel = 1'b0; key_valid = 1'b1; #1;
    chk("mux_ui", 32'(mode_out), 32'b01);
    sel = 1'b1; #1;
    chk("mux_sp", 32'(mode_out), 32'b10);
    key_valid = 1'b0; #1;
    chk("mux_idle1", 32'(mode_out), 32'b00);
    sel = 1'b0; #1;
    chk("mux_idle0", 32'(mode_out), 32'b00);

    // 3. comparator
    ui_code = 32'h2193_5488; sp_code = 32'h2193_5488; #1;
    chk("eq_same", 32'(code_eq), 32'd1);
    sp_code = 32'h2193_5477; #1;
    chk("eq_diff", 32'(code_eq), 32'd0);
    sp_code = 32'h2193_5489; #1;
    chk("eq_bit0", 32'(code_eq), 32'd0);
    sp_code = 32'hA193_5488; #1;
    chk("eq_bit31", 32'(code_eq), 32'd0);
    ui_code = 32'hFEDC_BA98; sp_code = 32'hFEDC_BA98; #1;
    chk("eq_illegal", 32'(code_eq), 32'd1);

    // 4. ten pulses with wrap on the tenth
    async_reset();
    chk("r4_count", 32'(attempt_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      attempt_inc = 1'b1; #1;
      chk("wrap_pre", 32'(attempt_wrap), (i == 9) ? 32'd1 : 32'd0);
      edge_dly();
      attempt_inc = 1'b0;
      chk("seq_count", 32'(attempt_count), 32'(exp_seq[i]));
      #3;
    end

    // 5. async reset mid-count, inc pulse during reset lost
    for (int i = 0; i < 6; i++) pulse();
    chk("at_six", 32'(attempt_count), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_clr", 32'(attempt_count), 32'd0);
    attempt_inc = 1'b1;
    edge_dly();
    chk("inc_in_rst", 32'(attempt_count), 32'd0);
    attempt_inc = 1'b0;
    rst = 1'b0;
    #2;
    pulse();
    chk("post_rst", 32'(attempt_count), 32'd1);

    // 6. held high 13 cycles
    async_reset();
    attempt_inc = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      edge_dly();
      chk("hold_cnt", 32'(attempt_count), 32'(i % 10));
    end
    attempt_inc = 1'b0;
    edge_dly();
    chk("hold_final", 32'(attempt_count), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
